// File: rtl/axi_dmem_slave.sv
// axi_dmem_slave: AXI4-lite slave data memory with byte-strobed writes and single-beat reads
//
// Optional feature: define DMEM_ADDR_CHECK_EN to answer SLVERR for addresses outside
// [BASE_ADDR, BASE_ADDR + 4*MEM_DEPTH). Without it, addresses alias modulo the array size.
//
// Ports:
//   ACLK, ARESETn                       clock, asynchronous active-low reset
//   AWVALID/AWREADY, AWADDR, AWPROT     write address channel (AWPROT ignored)
//   WVALID/WREADY, WDATA, WSTRB         write data channel
//   BVALID/BREADY, BRESP                write response channel
//   ARVALID/ARREADY, ARADDR, ARPROT     read address channel (ARPROT ignored)
//   RVALID/RREADY, RDATA, RRESP         read data channel
module axi_dmem_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int MEM_DEPTH = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic [2:0]                AWPROT,
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic [AXI_DATA_WIDTH-1:0] WDATA,
    input  logic [AXI_STRB_WIDTH-1:0] WSTRB,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic [1:0]                BRESP,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    input  logic [2:0]                ARPROT,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [AXI_DATA_WIDTH-1:0] RDATA,
    output logic [1:0]                RRESP
);
    localparam int IW = $clog2(MEM_DEPTH);
    typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
    wr_state_t wr_state, wr_state_n;
    rd_state_t rd_state, rd_state_n;
    logic aw_held, w_held, aw_held_n, w_held_n;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, wr_ok, rd_ok;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr, aw_off, ar_off;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic [IW-1:0] aw_idx, ar_idx;
    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic unused;
    assign aw_off = aw_addr - BASE_ADDR;
    assign ar_off = ARADDR - BASE_ADDR;
    assign aw_idx = aw_off[IW+1:2];
    assign ar_idx = ar_off[IW+1:2];
`ifdef DMEM_ADDR_CHECK_EN
    localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(4 * MEM_DEPTH);
    assign wr_ok = aw_off < SPAN;
    assign rd_ok = ar_off < SPAN;
`else
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
`endif
    assign unused = ^{1'b0, AWPROT, ARPROT, aw_off, ar_off};
    assign aw_hs = AWVALID && AWREADY;
    assign w_hs = WVALID && WREADY;
    assign b_hs = BVALID && BREADY;
    assign ar_hs = ARVALID && ARREADY;
    assign r_hs = RVALID && RREADY;
    // Both halves held means the pair is complete; it commits this cycle and the flags drop.
    assign commit = aw_held && w_held;
    always_comb begin
        wr_state_n = commit ? WR_RESP : (b_hs ? WR_COLLECT : wr_state);
        aw_held_n = !commit && (aw_held || aw_hs);
        w_held_n = !commit && (w_held || w_hs);
        rd_state_n = ar_hs ? RD_DATA : (r_hs ? RD_IDLE : rd_state);
    end
    // Readies and valids are registered from next state so nothing depends combinationally on a VALID.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state <= WR_COLLECT;
            rd_state <= RD_IDLE;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            aw_addr <= '0;
            w_data <= '0;
            w_strb <= '0;
            AWREADY <= 1'b0;
            WREADY <= 1'b0;
            ARREADY <= 1'b0;
            BVALID <= 1'b0;
            BRESP <= 2'b00;
            RVALID <= 1'b0;
            RRESP <= 2'b00;
            RDATA <= '0;
        end else begin
            wr_state <= wr_state_n;
            rd_state <= rd_state_n;
            aw_held <= aw_held_n;
            w_held <= w_held_n;
            AWREADY <= wr_state_n == WR_COLLECT && !aw_held_n;
            WREADY <= wr_state_n == WR_COLLECT && !w_held_n;
            ARREADY <= rd_state_n == RD_IDLE;
            BVALID <= wr_state_n == WR_RESP;
            RVALID <= rd_state_n == RD_DATA;
            if (aw_hs) aw_addr <= AWADDR;
            if (w_hs) begin
                w_data <= WDATA;
                w_strb <= WSTRB;
            end
            if (commit) BRESP <= wr_ok ? 2'b00 : 2'b10;
            // Array read uses the pre-edge contents, so a same-cycle commit is not visible yet.
            if (ar_hs) begin
                RDATA <= rd_ok ? mem[ar_idx] : '0;
                RRESP <= rd_ok ? 2'b00 : 2'b10;
            end
        end
    end
    // Contents are deliberately not reset; a commit is only possible while out of reset.
    always_ff @(posedge ACLK) begin
        if (commit && wr_ok)
            for (int i = 0; i < AXI_STRB_WIDTH; i++)
                if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
    end
endmodule

// File: tb/tb_axi_dmem_slave.sv
// tb_axi_dmem_slave: scoreboard bench for axi_dmem_slave (BASE_ADDR 0, MEM_DEPTH 1024)
module tb_axi_dmem_slave;
    logic ACLK, ARESETn;
    logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0] WSTRB;
    logic [2:0] AWPROT, ARPROT;
    logic [1:0] BRESP, RRESP;
    typedef struct {
        logic [31:0] d;
        logic [1:0] r;
    } rexp_t;
    logic [1:0] exp_b [$];
    rexp_t exp_r [$];
    logic [31:0] model [int];
    int n_tests = 0;
    int n_fail = 0;

    axi_dmem_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_STRB_WIDTH(4),
                     .MEM_DEPTH(1024), .BASE_ADDR(32'h0)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
        return a < 32'h1000;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    always @(negedge ACLK) begin
        if (ARESETn && BVALID && BREADY) begin
            if (exp_b.size() == 0) check("b_extra", 32'(exp_b.size()), 32'd1);
            else check("bresp", 32'(BRESP), 32'(exp_b.pop_front()));
        end
        if (ARESETn && RVALID && RREADY) begin
            if (exp_r.size() == 0) check("r_extra", 32'(exp_r.size()), 32'd1);
            else begin
                rexp_t e;
                e = exp_r.pop_front();
                check("rdata", RDATA, e.d);
                check("rresp", 32'(RRESP), 32'(e.r));
            end
        end
    end

    task automatic reset_chk(input string tag);
        check({tag, "_awready"}, 32'(AWREADY), 32'd0);
        check({tag, "_wready"}, 32'(WREADY), 32'd0);
        check({tag, "_arready"}, 32'(ARREADY), 32'd0);
        check({tag, "_bvalid"}, 32'(BVALID), 32'd0);
        check({tag, "_bresp"}, 32'(BRESP), 32'd0);
        check({tag, "_rvalid"}, 32'(RVALID), 32'd0);
        check({tag, "_rresp"}, 32'(RRESP), 32'd0);
        check({tag, "_rdata"}, RDATA, 32'd0);
    endtask

    // Waits (bounded) for the readies of the raised valids, lets the handshake edge pass, drops the valids.
    task automatic hs(input bit aw, input bit w, input bit ar);
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if ((!aw || AWREADY) && (!w || WREADY) && (!ar || ARREADY)) break;
        end
        check("hs_ready", 32'((!aw || AWREADY) && (!w || WREADY) && (!ar || ARREADY)), 32'd1);
        @(posedge ACLK);
        #1;
        if (aw) AWVALID = 1'b0;
        if (w) WVALID = 1'b0;
        if (ar) ARVALID = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge ACLK);
            check("no_early_b", 32'(BVALID), 32'd0);
        end
        @(posedge ACLK);
        #1;
    endtask

    // order: 0 AW and W together, >0 W first then AW after 'order' idle cycles, <0 AW first.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int order, input int hold);
        logic [1:0] r;
        logic [31:0] m;
        int lat;
        r = addr_ok(a) ? 2'b00 : 2'b10;
        exp_b.push_back(r);
        if (r == 2'b00) begin
            m = model.exists(idx(a)) ? model[idx(a)] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
            model[idx(a)] = m;
        end
        if (hold > 0) BREADY = 1'b0;
        if (order >= 0) begin WVALID = 1'b1; WDATA = d; WSTRB = s; end
        if (order <= 0) begin AWVALID = 1'b1; AWADDR = a; end
        if (order == 0) hs(1, 1, 0);
        else if (order > 0) begin
            hs(0, 1, 0);
            gap(order);
            AWVALID = 1'b1;
            AWADDR = a;
            hs(1, 0, 0);
        end else begin
            hs(1, 0, 0);
            gap(-order);
            WVALID = 1'b1;
            WDATA = d;
            WSTRB = s;
            hs(0, 1, 0);
        end
        lat = 1;
        @(negedge ACLK);
        while (!BVALID && lat < 10) begin
            lat++;
            @(negedge ACLK);
        end
        check("b_latency", 32'(lat), 32'd2);
        for (int k = 0; k < hold; k++) begin
            check("b_hold_valid", 32'(BVALID), 32'd1);
            check("b_hold_resp", 32'(BRESP), 32'(r));
            check("b_hold_awready", 32'(AWREADY), 32'd0);
            check("b_hold_wready", 32'(WREADY), 32'd0);
            @(negedge ACLK);
        end
        if (hold > 0) begin
            @(posedge ACLK);
            #1;
            BREADY = 1'b1;
        end
        @(posedge ACLK);
        #1;
        check("b_clear", 32'(BVALID), 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, input int hold);
        rexp_t e;
        int lat;
        e.r = addr_ok(a) ? 2'b00 : 2'b10;
        e.d = addr_ok(a) ? model[idx(a)] : 32'h0;
        exp_r.push_back(e);
        if (hold > 0) RREADY = 1'b0;
        ARVALID = 1'b1;
        ARADDR = a;
        hs(0, 0, 1);
        lat = 1;
        @(negedge ACLK);
        while (!RVALID && lat < 10) begin
            lat++;
            @(negedge ACLK);
        end
        check("r_latency", 32'(lat), 32'd1);
        for (int k = 0; k < hold; k++) begin
            check("r_hold_valid", 32'(RVALID), 32'd1);
            check("r_hold_data", RDATA, e.d);
            check("r_hold_arready", 32'(ARREADY), 32'd0);
            @(negedge ACLK);
        end
        if (hold > 0) begin
            @(posedge ACLK);
            #1;
            RREADY = 1'b1;
        end
        @(posedge ACLK);
        #1;
        check("r_clear", 32'(RVALID), 32'd0);
    endtask

    initial begin
        ARESETn = 1'b0;
        AWVALID = 1'b0; AWADDR = '0; AWPROT = '0;
        WVALID = 1'b0; WDATA = '0; WSTRB = '0;
        ARVALID = 1'b0; ARADDR = '0; ARPROT = '0;
        BREADY = 1'b1; RREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        reset_chk("rst");
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        check("rel_awready", 32'(AWREADY), 32'd1);
        check("rel_wready", 32'(WREADY), 32'd1);
        check("rel_arready", 32'(ARREADY), 32'd1);
        @(posedge ACLK);
        #1;
        wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        rd(32'h10, 0);
        wr(32'h10, 32'h11223344, 4'b0101, 3, 0);
        rd(32'h10, 0);
        wr(32'h18, 32'h0F0F0F0F, 4'hF, -2, 0);
        rd(32'h18, 0);
        wr(32'h1C, 32'h99999999, 4'h0, 0, 0);
        wr(32'h40, 32'h13579BDF, 4'hF, 0, 5);
        rd(32'h40, 5);
        wr(32'h20, 32'h12345678, 4'hF, 0, 0);
        rd(32'h20, 0);
        exp_b.push_back(2'b00);
        exp_r.push_back('{d: model[8], r: 2'b00});
        model[8] = 32'hAAAA5555;
        AWVALID = 1'b1; AWADDR = 32'h20;
        WVALID = 1'b1; WDATA = 32'hAAAA5555; WSTRB = 4'hF;
        hs(1, 1, 0);
        ARVALID = 1'b1;
        ARADDR = 32'h20;
        @(negedge ACLK);
        check("coll_arready", 32'(ARREADY), 32'd1);
        @(posedge ACLK);
        #1;
        ARVALID = 1'b0;
        @(negedge ACLK);
        check("coll_bvalid", 32'(BVALID), 32'd1);
        check("coll_rvalid", 32'(RVALID), 32'd1);
        @(posedge ACLK);
        #1;
        rd(32'h20, 0);
        wr(32'h0, 32'h01020304, 4'hF, 0, 0);
        wr(32'h1000, 32'hCAFEF00D, 4'hF, 0, 0);
        rd(32'h1000, 0);
        rd(32'h0, 0);
        wr(32'h30, 32'h55AA55AA, 4'hF, 0, 0);
        RREADY = 1'b0;
        ARVALID = 1'b1;
        ARADDR = 32'h30;
        hs(0, 0, 1);
        AWVALID = 1'b1;
        AWADDR = 32'h30;
        hs(1, 0, 0);
        check("pre_rst_rvalid", 32'(RVALID), 32'd1);
        #2;
        ARESETn = 1'b0;
        #1;
        reset_chk("mid");
        RREADY = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        rd(32'h30, 0);
        wr(32'h30, 32'h0BADCAFE, 4'hF, 0, 0);
        rd(32'h30, 0);
        repeat (3) @(posedge ACLK);
        check("b_left", 32'(exp_b.size()), 32'd0);
        check("r_left", 32'(exp_r.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
